vreg_write_collector: RTL and testbench
=======================================

// Module: vreg_write_collector
// PURPOSE
// Write-back stage directly upstream of the per-bank write arbiters. Captures one batch of up to PORT_NUM
// vector-register write requests and holds address and data stable. Drives a per-port "already written" mask
// (vreg_write_select, 1 = written or not requesting) to all BANK_NUM arbiters. ORs the returned bank grants
// into that mask each cycle, and accepts a new batch only once every request in the current batch has retired.
// PARAMETERS
// PORT_NUM       2    write ports per batch
// ADDR_WIDTH     6    vreg address width ({Y,X} packed, X in LSBs)
// DATA_WIDTH     128  write data width per port
// BANK_NUM       4    number of bank arbiters returning grants (one per X_Y quadrant)
// TIMEOUT_CYCLES 64   drain watchdog limit (only with VREG_WRITE_TIMEOUT_EN)
// PORTS
// clk                  in   1                       clock
// rst                  in   1                       synchronous, active-high reset
// in_valid             in   PORT_NUM                per-port request in offered batch
// in_addr              in   PORT_NUM*ADDR_WIDTH     per-port vreg address
// in_data              in   PORT_NUM*DATA_WIDTH     per-port write data
// in_ready             out  1                       batch accepted when in_ready & |in_valid
// vreg_addr            out  PORT_NUM*ADDR_WIDTH     held batch addresses, to all bank arbiters
// vreg_data            out  PORT_NUM*DATA_WIDTH     held batch data, to bank write ports
// vreg_write_select    out  PORT_NUM                done mask; 0 = still requesting
// bank_grant           in   BANK_NUM*PORT_NUM       bank_write_select from each arbiter
// batch_done           out  1                       one-cycle pulse when last request of batch retires
// err                  out  1                       sticky protocol error
// timeout              out  1                       sticky watchdog flag (0 when macro absent)
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high (rst).
// - Reset values: state IDLE. vreg_addr=0, vreg_data=0, vreg_write_select=all 1s, batch_done=0, err=0, timeout=0.
//   in_ready=0 while rst is high.
// - FSM IDLE/DRAIN. in_ready = (state==IDLE) & ~rst. In IDLE, |in_valid is ignored when 0.
// - Capture (IDLE, |in_valid): register addr/data. mask[i] <= ~in_valid[i]. Go to DRAIN.
//   Requests are visible to the arbiters from the next cycle (1-cycle capture latency).
// - Same-address rule at capture: if valid ports i<j hold equal addresses, mask[i] <= 1 (higher index wins; lower dropped).
// - DRAIN, each cycle: g = OR over banks of bank_grant[b]. mask <= mask | g.
//   If (mask|g) is all 1s: batch_done=1 for that cycle, next state IDLE, new batch accepted the following cycle.
// - Minimum batch occupancy is 2 cycles (capture + >=1 drain). in_ready is never asserted during DRAIN.
// - err set (sticky until rst) when any of the following occurs:
//   - a grant arrives for a port whose mask bit is already 1 (grant ignored);
//   - two banks grant the same port in one cycle;
//   - any grant arrives in IDLE.
// - addr/data are held unchanged throughout DRAIN. Arbiters read no data from this block.
// - rst mid-DRAIN: batch discarded, no batch_done, back to IDLE with all-ones mask.
// - Grants are sampled only in DRAIN. Combinational path bank_grant->batch_done only; no path in_*->outputs.
// CONFIGURATION
// - VREG_WRITE_TIMEOUT_EN defined:
//   - counter cleared on capture, increments each DRAIN cycle.
//   - at TIMEOUT_CYCLES DRAIN cycles without completion: timeout set (sticky), mask forced all 1s, batch_done
//     pulses, FSM returns to IDLE.
// - VREG_WRITE_TIMEOUT_EN undefined: no counter, timeout tied 0, DRAIN waits indefinitely.
// TESTING
// - Reset then idle: vreg_write_select=2'b11, in_ready=1 after rst drops, batch_done=0, err=0.
// - in_valid=11, addr0=0x00, addr1=0x21; bank0 grants port0 next cycle, bank3 grants port1 the cycle after
//   -> mask 00->01->11, batch_done on 2nd drain cycle, in_ready=1 the cycle after.
// - in_valid=01, addr0=0x05 -> mask captured 10; single grant to port0 -> batch_done same cycle, 2-cycle occupancy.
// - in_valid=11, addr0=addr1=0x04 -> mask captured 01, only port1 requests, single grant completes batch.
// - Faults: repeat grant to port0 after it is done -> err=1, mask unchanged; two banks granting port1 together
//   -> err=1; rst mid-DRAIN -> IDLE, mask 11, no batch_done.
// - With VREG_WRITE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no grants -> timeout=1 and batch_done after 8 DRAIN cycles;
//   without the macro -> stays in DRAIN.

Source files
------------

// File: rtl/vreg_write_collector_if.sv
// ============================================================================
// Module   : vreg_write_collector_if
// Purpose  : Bundles the batch-input handshake, the held write bus and the
//            bank-grant return path of the vreg write collector.
// Modports : slave  - collector side (inputs: in_*, bank_grant)
//            master - producer + bank-arbiter side
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vreg_write_collector_if #(
    parameter int PORT_NUM   = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int BANK_NUM   = 4
);
    logic [PORT_NUM-1:0]            in_valid;
    logic [PORT_NUM*ADDR_WIDTH-1:0] in_addr;
    logic [PORT_NUM*DATA_WIDTH-1:0] in_data;
    logic                           in_ready;
    logic [PORT_NUM*ADDR_WIDTH-1:0] vreg_addr;
    logic [PORT_NUM*DATA_WIDTH-1:0] vreg_data;
    logic [PORT_NUM-1:0]            vreg_write_select;
    logic [BANK_NUM*PORT_NUM-1:0]   bank_grant;
    logic                           batch_done;
    logic                           err;
    logic                           timeout;

    modport slave (
        input  in_valid, in_addr, in_data, bank_grant,
        output in_ready, vreg_addr, vreg_data, vreg_write_select,
               batch_done, err, timeout
    );

    modport master (
        output in_valid, in_addr, in_data, bank_grant,
        input  in_ready, vreg_addr, vreg_data, vreg_write_select,
               batch_done, err, timeout
    );
endinterface

`default_nettype wire

// File: rtl/vreg_write_collector.sv
// ============================================================================
// Module   : vreg_write_collector
// Purpose  : Captures one batch of up to PORT_NUM vreg write requests, holds
//            address/data stable for the bank arbiters and folds returned
//            bank grants into a per-port done mask until the batch retires.
// Ports    : clk, rst (sync, active-high)
//            bus (slave modport): in_valid/in_addr/in_data/in_ready batch
//            handshake; vreg_addr/vreg_data/vreg_write_select to arbiters;
//            bank_grant from arbiters; batch_done, err, timeout status.
// Config   : VREG_WRITE_TIMEOUT_EN - enables the drain watchdog
//            (TIMEOUT_CYCLES drain cycles); otherwise timeout is tied 0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vreg_write_collector #(
    parameter int PORT_NUM       = 2,
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 128,
    parameter int BANK_NUM       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire                     clk,
    input  wire                     rst,
    vreg_write_collector_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [PORT_NUM-1:0]            r_mask;
    logic [PORT_NUM-1:0]            w_mask_next;
    logic [PORT_NUM-1:0]            w_cap_mask;
    logic [PORT_NUM-1:0]            w_drain_mask;
    logic [PORT_NUM-1:0]            w_grant;
    logic [PORT_NUM-1:0]            w_grant_dbl;
    logic [PORT_NUM*ADDR_WIDTH-1:0] r_addr;
    logic [PORT_NUM*DATA_WIDTH-1:0] r_data;
    logic                           r_err;
    logic                           w_err_set;
    logic                           w_capture;
    logic                           w_done;
    logic                           w_all_done;
    logic                           w_tmo_hit;

    // OR the per-bank grant vectors; any port already seen from an earlier
    // bank in the same cycle flags a double grant.
    always_comb begin
        w_grant     = '0;
        w_grant_dbl = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            w_grant_dbl = w_grant_dbl | (w_grant & bus.bank_grant[b*PORT_NUM +: PORT_NUM]);
            w_grant     = w_grant | bus.bank_grant[b*PORT_NUM +: PORT_NUM];
        end
    end

    // Capture mask: idle ports start done. When two valid ports target the
    // same vreg, the lower-index write is dropped so the higher one wins.
    always_comb begin
        w_cap_mask = ~bus.in_valid;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int j = i + 1; j < PORT_NUM; j++) begin
                if (bus.in_valid[i] && bus.in_valid[j] &&
                    (bus.in_addr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                     bus.in_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    w_cap_mask[i] = 1'b1;
                end
            end
        end
    end

    assign w_drain_mask = r_mask | w_grant;
    assign w_all_done   = &w_drain_mask;

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                // Arbiters must stay silent while nothing is requested.
                if (|w_grant) begin
                    w_err_set = 1'b1;
                end
                if (|bus.in_valid) begin
                    w_capture    = 1'b1;
                    w_mask_next  = w_cap_mask;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Grants to already-done ports leave the mask unchanged since
                // OR-ing a 1 into a 1 is a no-op; they only raise err.
                if ((|(w_grant & r_mask)) || (|w_grant_dbl)) begin
                    w_err_set = 1'b1;
                end
                w_mask_next = w_drain_mask;
                if (w_all_done || w_tmo_hit) begin
                    w_done       = 1'b1;
                    w_mask_next  = '1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_mask_next  = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= '1;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            if (w_capture) begin
                r_addr <= bus.in_addr;
                r_data <= bus.in_data;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef VREG_WRITE_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_tmo_cnt;
    logic               r_timeout;

    // r_tmo_cnt holds the number of completed drain cycles, so the hit fires
    // during the TIMEOUT_CYCLES-th drain cycle.
    assign w_tmo_hit = (r_state == DRAIN) &&
                       (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_capture) begin
                r_tmo_cnt <= '0;
            end else if (r_state == DRAIN) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_hit && !w_all_done) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_tmo_hit   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.in_ready          = (r_state == IDLE) && !rst;
    assign bus.batch_done        = w_done && !rst;
    assign bus.vreg_addr         = r_addr;
    assign bus.vreg_data         = r_data;
    assign bus.vreg_write_select = r_mask;
    assign bus.err               = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vreg_write_collector.sv
// ============================================================================
// Module   : tb_vreg_write_collector
// Purpose  : Self-checking bench for vreg_write_collector. Captured batches
//            are pushed to a scoreboard and popped on each batch_done pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vreg_write_collector;

    localparam int PN  = 2;
    localparam int AW  = 6;
    localparam int DW  = 128;
    localparam int BN  = 4;
    localparam int TMO = 8;

    typedef struct packed {
        logic [PN*AW-1:0] addr;
        logic [PN*DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    vreg_write_collector_if #(.PORT_NUM(PN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) bus ();

    vreg_write_collector #(
        .PORT_NUM(PN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Scoreboard consumer: every batch_done must retire the oldest batch,
    // with address/data still held as captured.
    always @(negedge clk) begin
        if (!rst && bus.batch_done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: batch_done=1 with empty scoreboard");
            end else begin
                mon_e = sb.pop_front();
                if (bus.vreg_addr !== mon_e.addr || bus.vreg_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL sb_held_bus: addr=%h exp=%h data=%h exp=%h",
                             bus.vreg_addr, mon_e.addr, bus.vreg_data, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one batch for one cycle, records the expectation, then scrambles
    // the inputs so held-bus checks catch any re-capture.
    task automatic offer(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        exp_t          e;
        d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_valid = v;
        bus.in_addr  = {a1, a0};
        bus.in_data  = {d1, d0};
        e.addr = {a1, a0};
        e.data = {d1, d0};
        sb.push_back(e);
        step();
        bus.in_valid = '0;
        bus.in_addr  = PN*AW'($urandom());
        bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid   = '0;
        bus.in_addr    = '0;
        bus.in_data    = '0;
        bus.bank_grant = '0;
        repeat (3) step();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready); end
        n_checks++; if (bus.vreg_write_select !== 2'b11) begin n_fail++; $display("FAIL reset_mask: got %b exp 11", bus.vreg_write_select); end
        n_checks++; if (bus.batch_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.batch_done); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", bus.err); end
        n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", bus.timeout); end
        n_checks++; if (bus.vreg_addr !== '0 || bus.vreg_data !== '0) begin n_fail++; $display("FAIL reset_bus: addr=%h data=%h exp 0", bus.vreg_addr, bus.vreg_data); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b exp 1", bus.in_ready); end
        step();
        n_checks++; if (bus.vreg_write_select !== 2'b11 || bus.batch_done !== 1'b0) begin n_fail++; $display("FAIL idle_state: mask=%b done=%b exp 11/0", bus.vreg_write_select, bus.batch_done); end
    endtask

    task automatic test_two_port();
        offer(2'b11, 6'h00, 6'h21);
        n_checks++; if (bus.vreg_write_select !== 2'b00) begin n_fail++; $display("FAIL two_mask_cap: got %b exp 00", bus.vreg_write_select); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL two_ready_drain: got %b exp 0", bus.in_ready); end
        n_checks++; if (bus.vreg_addr !== 12'h840) begin n_fail++; $display("FAIL two_addr: got %h exp 840", bus.vreg_addr); end
        bus.bank_grant = 8'h01;
        #1;
        n_checks++; if (bus.batch_done !== 1'b0) begin n_fail++; $display("FAIL two_done_early: got %b exp 0", bus.batch_done); end
        step();
        n_checks++; if (bus.vreg_write_select !== 2'b01) begin n_fail++; $display("FAIL two_mask_mid: got %b exp 01", bus.vreg_write_select); end
        bus.bank_grant = 8'h80;
        #1;
        n_checks++; if (bus.batch_done !== 1'b1) begin n_fail++; $display("FAIL two_done: got %b exp 1", bus.batch_done); end
        step();
        bus.bank_grant = '0;
        #1;
        n_checks++; if (bus.vreg_write_select !== 2'b11 || bus.in_ready !== 1'b1 || bus.batch_done !== 1'b0) begin n_fail++; $display("FAIL two_after: mask=%b ready=%b done=%b exp 11/1/0", bus.vreg_write_select, bus.in_ready, bus.batch_done); end
    endtask

    task automatic test_single_port();
        offer(2'b01, 6'h05, 6'h3f);
        n_checks++; if (bus.vreg_write_select !== 2'b10) begin n_fail++; $display("FAIL single_mask_cap: got %b exp 10", bus.vreg_write_select); end
        bus.bank_grant = 8'h04;
        #1;
        n_checks++; if (bus.batch_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b exp 1", bus.batch_done); end
        step();
        bus.bank_grant = '0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1 || bus.vreg_write_select !== 2'b11) begin n_fail++; $display("FAIL single_after: ready=%b mask=%b exp 1/11", bus.in_ready, bus.vreg_write_select); end
    endtask

    task automatic test_same_addr();
        offer(2'b11, 6'h04, 6'h04);
        n_checks++; if (bus.vreg_write_select !== 2'b01) begin n_fail++; $display("FAIL same_mask_cap: got %b exp 01", bus.vreg_write_select); end
        bus.bank_grant = 8'h02;
        #1;
        n_checks++; if (bus.batch_done !== 1'b1) begin n_fail++; $display("FAIL same_done: got %b exp 1", bus.batch_done); end
        step();
        bus.bank_grant = '0;
        #1;
        n_checks++; if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL same_after: err=%b ready=%b exp 0/1", bus.err, bus.in_ready); end
    endtask

    task automatic test_faults();
        // Repeat grant to a port that is already done.
        offer(2'b11, 6'h01, 6'h02);
        bus.bank_grant = 8'h01;
        step();
        n_checks++; if (bus.vreg_write_select !== 2'b01 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rep_first: mask=%b err=%b exp 01/0", bus.vreg_write_select, bus.err); end
        step();
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL rep_err: got %b exp 1", bus.err); end
        n_checks++; if (bus.vreg_write_select !== 2'b01) begin n_fail++; $display("FAIL rep_mask: got %b exp 01", bus.vreg_write_select); end
        bus.bank_grant = 8'h08;
        step();
        bus.bank_grant = '0;
        // Two banks granting port1 in the same cycle.
        rst = 1'b1; step(); rst = 1'b0;
        #1;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", bus.err); end
        offer(2'b11, 6'h10, 6'h11);
        bus.bank_grant = 8'h22;
        step();
        n_checks++; if (bus.err !== 1'b1 || bus.vreg_write_select !== 2'b10) begin n_fail++; $display("FAIL dbl_err: err=%b mask=%b exp 1/10", bus.err, bus.vreg_write_select); end
        bus.bank_grant = 8'h01;
        step();
        bus.bank_grant = '0;
        // Grant while idle.
        rst = 1'b1; step(); rst = 1'b0;
        bus.bank_grant = 8'h10;
        step();
        bus.bank_grant = '0;
        #1;
        n_checks++; if (bus.err !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_grant: err=%b ready=%b exp 1/1", bus.err, bus.in_ready); end
        // Reset in the middle of a drain discards the batch.
        rst = 1'b1; step(); rst = 1'b0;
        offer(2'b11, 6'h20, 6'h30);
        bus.bank_grant = 8'h01;
        step();
        rst = 1'b1;
        bus.bank_grant = 8'h80;
        #1;
        n_checks++; if (bus.batch_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b exp 0", bus.batch_done); end
        step();
        rst = 1'b0;
        bus.bank_grant = '0;
        sb.delete();
        #1;
        n_checks++; if (bus.vreg_write_select !== 2'b11 || bus.in_ready !== 1'b1 || bus.batch_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: mask=%b ready=%b done=%b exp 11/1/0", bus.vreg_write_select, bus.in_ready, bus.batch_done); end
    endtask

    task automatic test_timeout();
        offer(2'b11, 6'h07, 6'h08);
`ifdef VREG_WRITE_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            n_checks++; if (bus.batch_done !== (k == TMO) || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_cycle%0d: done=%b timeout=%b exp %b/0", k, bus.batch_done, bus.timeout, (k == TMO)); end
            step();
        end
        n_checks++; if (bus.timeout !== 1'b1 || bus.vreg_write_select !== 2'b11 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_after: timeout=%b mask=%b ready=%b exp 1/11/1", bus.timeout, bus.vreg_write_select, bus.in_ready); end
`else
        for (int k = 1; k <= 3*TMO; k++) begin
            n_checks++; if (bus.batch_done !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL notmo_cycle%0d: done=%b ready=%b exp 0/0", k, bus.batch_done, bus.in_ready); end
            step();
        end
        n_checks++; if (bus.timeout !== 1'b0 || bus.vreg_write_select !== 2'b00) begin n_fail++; $display("FAIL notmo_hold: timeout=%b mask=%b exp 0/00", bus.timeout, bus.vreg_write_select); end
        bus.bank_grant = 8'h03;
        #1;
        n_checks++; if (bus.batch_done !== 1'b1) begin n_fail++; $display("FAIL notmo_done: got %b exp 1", bus.batch_done); end
        step();
        bus.bank_grant = '0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL notmo_after: ready=%b exp 1", bus.in_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_two_port();
        test_single_port();
        test_same_addr();
        test_faults();
        test_timeout();
        step();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d batches never retired, exp 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
